mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM->WB stage of the RV32I pipeline. Accepts one retiring instruction per handshake from the
//  memory stage, waits for the data-memory response on loads, and aligns/extends the load data.
//  Drives the register file write port (RegWrite, rd, rd_write_data) with a one-cycle write pulse.
//  Holds at most one instruction. A pipeline flush can kill an in-flight load.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  CNT_W     64  width of the retire counter (RETIRE_CNT_EN only)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  in_valid       in   1      MEM stage presents an instruction
//  in_ready       out  1      stage can accept; transfer when in_valid & in_ready
//  in_reg_write   in   1      instruction writes rd
//  in_rd          in   5      destination register
//  in_wb_sel      in   2      0=ALU result, 1=load data, 2=pc_plus4, 3=reserved (treated as 0)
//  in_funct3      in   3      load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
//  in_addr_lo     in   2      byte offset of the load address
//  in_alu_result  in   32     ALU result
//  in_pc_plus4    in   32     PC+4 for JAL/JALR
//  flush          in   1      kill held/arriving instruction
//  dmem_rvalid    in   1      load data valid
//  dmem_rdata     in   32     raw 32-bit word from data memory
//  RegWrite       out  1      register file write enable (registered)
//  rd             out  5      register file write address (registered)
//  rd_write_data  out  32     register file write data (registered)
//  instret        out  CNT_W  retired-instruction count (present only with RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset: state=EMPTY; RegWrite=0, rd=0, rd_write_data=0, instret=0. in_ready=1 after reset.
//  - States: EMPTY, LOAD_WAIT, DRAIN.
//    EMPTY: in_ready=1. An accept with flush=0:
//      wb_sel!=1 -> stay EMPTY. Next cycle RegWrite=in_reg_write&(in_rd!=0), rd=in_rd.
//        rd_write_data is the ALU result or pc_plus4. Latency 1.
//      wb_sel==1 -> capture reg_write/rd/funct3/addr_lo, then go to LOAD_WAIT.
//      flush=1 in EMPTY: in_ready stays 1; any arriving instruction is discarded (no write, no count).
//    LOAD_WAIT: in_ready=0.
//      dmem_rvalid=1, flush=0 -> go to EMPTY. Next cycle: write pulse with formatted data,
//        gated by rd!=0 and reg_write.
//      flush=1 with dmem_rvalid=0 -> go to DRAIN.
//      flush=1 with dmem_rvalid=1 -> go to EMPTY with no write.
//    DRAIN: in_ready=0. Discard data on dmem_rvalid, then go to EMPTY. flush is ignored.
//  - dmem_rvalid outside LOAD_WAIT/DRAIN is ignored. It is earliest valid the cycle after accept.
//  - RegWrite is high for exactly one cycle per write and is 0 otherwise.
//    rd/rd_write_data hold their last values when RegWrite=0.
//  - Load format:
//    byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16] (addr_lo[0] ignored).
//    LB/LH sign-extend; LBU/LHU zero-extend; LW ignores addr_lo.
//    funct3 values 3, 6, 7 are treated as LW.
//  - No write-collision handling: a load write and a following ALU write never share a cycle,
//    because in_ready=0 in LOAD_WAIT.
//  - rst has priority over all inputs. Reset mid-load returns to EMPTY and any later rvalid is ignored.
// CONFIGURATION
//  RETIRE_CNT_EN defined:
//    instret port exists.
//    Increments by 1 on the cycle each accepted, unflushed instruction completes
//      (non-load: the accept cycle; load: the rvalid cycle), whether or not it writes rd.
//    Wraps modulo 2^CNT_W.
//  Not defined: no instret port, no counter logic. All other behaviour is identical.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> RegWrite=0, rd=0, rd_write_data=0, in_ready=1, instret=0.
//  2. ALU: accept rd=5, wb_sel=0, alu=0xDEADBEEF -> next cycle RegWrite=1, rd=5,
//     data 0xDEADBEEF; 0 the cycle after.
//  3. LB: addr_lo=3, rvalid after 2 wait cycles, rdata=0x80FF0000 -> in_ready=0 while waiting;
//     cycle after rvalid: data 0xFFFFFF80.
//     LHU: addr_lo=2, rdata=0x80011234 -> 0x00008001.
//  4. rd=0: accept in_reg_write=1, rd=0, alu=0x1234 -> RegWrite stays 0.
//     instret increments (with RETIRE_CNT_EN).
//  5. Flush: load accepted; flush=1 in LOAD_WAIT -> DRAIN; rvalid after 3 cycles -> no write.
//     in_ready=1 the cycle after; instret unchanged.
//  6. JAL: accept wb_sel=2, pc_plus4=0x00000104, rd=1 -> next cycle RegWrite=1, rd=1, data 0x104.
//     Back-to-back accepts give writes on consecutive cycles.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage for RV32I: accepts one retiring instruction, waits for the
// data-memory response on loads, formats load data and pulses the register-file write port.
// Optional feature macro: RETIRE_CNT_EN adds the instret retire counter port and logic.
module mem_wb_stage #(
  parameter int unsigned XLEN = 32
`ifdef RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            flush,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_write_data
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    LOAD_WAIT = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  state_t      state;
  logic        ld_reg_write;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;

  // Select the addressed byte/halfword of a load word and extend it per funct3.
  function automatic logic [XLEN-1:0] format_load(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] result;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'd0:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'd1:    result = {{(XLEN-16){half_v[15]}}, half_v};
      3'd4:    result = {{(XLEN-8){1'b0}}, byte_v};
      3'd5:    result = {{(XLEN-16){1'b0}}, half_v};
      default: result = word;
    endcase
    return result;
  endfunction

  // Stage FSM: tracks the outstanding load and drives the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      in_ready      <= 1'b1;
      RegWrite      <= 1'b0;
      rd            <= 5'd0;
      rd_write_data <= '0;
      ld_reg_write  <= 1'b0;
      ld_rd         <= 5'd0;
      ld_funct3     <= 3'd0;
      ld_addr_lo    <= 2'd0;
`ifdef RETIRE_CNT_EN
      instret       <= '0;
`endif
    end else begin
      RegWrite <= 1'b0;
      case (state)
        EMPTY: begin
          if (in_valid && !flush) begin
            if (in_wb_sel == WB_LOAD) begin
              ld_reg_write <= in_reg_write;
              ld_rd        <= in_rd;
              ld_funct3    <= in_funct3;
              ld_addr_lo   <= in_addr_lo;
              state        <= LOAD_WAIT;
              in_ready     <= 1'b0;
            end else begin
              // rd/data only move on an actual write so they hold between pulses
              if (in_reg_write && (in_rd != 5'd0)) begin
                RegWrite      <= 1'b1;
                rd            <= in_rd;
                rd_write_data <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
              end
`ifdef RETIRE_CNT_EN
              instret <= instret + CNT_W'(1);
`endif
            end
          end
        end
        LOAD_WAIT: begin
          if (dmem_rvalid) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            if (!flush) begin
              if (ld_reg_write && (ld_rd != 5'd0)) begin
                RegWrite      <= 1'b1;
                rd            <= ld_rd;
                rd_write_data <= format_load(ld_funct3, ld_addr_lo, dmem_rdata);
              end
`ifdef RETIRE_CNT_EN
              instret <= instret + CNT_W'(1);
`endif
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // killed load: swallow its response, flush has no further effect
          if (dmem_rvalid) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;
`ifdef RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_cnt  = 64'd0;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .flush         (flush),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .RegWrite      (RegWrite),
    .rd            (rd),
    .rd_write_data (rd_write_data)
`ifdef RETIRE_CNT_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_rd         = 5'd0;
    in_wb_sel     = 2'd0;
    in_funct3     = 3'd0;
    in_addr_lo    = 2'd0;
    in_alu_result = 32'd0;
    in_pc_plus4   = 32'd0;
    flush         = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'd0;
  endtask

  // Reference load formatting written from the byte/half extraction rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = w >> (8 * int'(lo));
    hsh = w >> (16 * int'(lo[1]));
    case (f3)
      3'd0:    return 32'($signed(bsh[7:0]));
      3'd1:    return 32'($signed(hsh[15:0]));
      3'd4:    return {24'd0, bsh[7:0]};
      3'd5:    return {16'd0, hsh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_cnt = 64'd0;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    n_checks++; if (rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd); end
    n_checks++; if (rd_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_write_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret); end
`endif
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd5; in_wb_sel = 2'd0;
    in_alu_result = 32'hDEADBEEF; in_pc_plus4 = 32'h0000_0004;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b expected 1", in_ready); end
    step();
    idle_inputs();
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite); end
    n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", rd); end
    n_checks++; if (rd_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data: got %h expected deadbeef", rd_write_data); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL alu_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_pulse_end: got %b expected 0", RegWrite); end
    n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd_hold: got %0d expected 5", rd); end
  endtask

  task automatic test_load();
    // LB, byte 3, response after two empty wait cycles
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd10; in_wb_sel = 2'd1;
    in_funct3 = 3'd0; in_addr_lo = 2'd3;
    step();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_wait_ready: got %b expected 0", in_ready); end
      n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL lb_wait_regwrite: got %b expected 0", RegWrite); end
      step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF0000;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_rvalid_ready: got %b expected 0", in_ready); end
    step();
    idle_inputs();
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL lb_regwrite: got %b expected 1", RegWrite); end
    n_checks++; if (rd !== 5'd10) begin n_fail++; $display("FAIL lb_rd: got %0d expected 10", rd); end
    n_checks++; if (rd_write_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", rd_write_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_after: got %b expected 1", in_ready); end
    // LHU, upper half, response at the earliest legal cycle
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd11; in_wb_sel = 2'd1;
    in_funct3 = 3'd5; in_addr_lo = 2'd2;
    step();
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80011234;
    step();
    idle_inputs();
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL lhu_regwrite: got %b expected 1", RegWrite); end
    n_checks++; if (rd_write_data !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data: got %h expected 00008001", rd_write_data); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL load_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
    step();
  endtask

  task automatic test_rd_zero();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd0; in_wb_sel = 2'd0;
    in_alu_result = 32'h0000_1234;
    step();
    idle_inputs();
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rd0_regwrite: got %b expected 0", RegWrite); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL rd0_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
    step();
  endtask

  task automatic test_flush();
    // flush kills a waiting load; its late response is swallowed
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd12; in_wb_sel = 2'd1; in_funct3 = 3'd2;
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain_ready: got %b expected 0", in_ready); end
      step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    step();
    idle_inputs();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite: got %b expected 0", RegWrite); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b expected 1", in_ready); end
    // flush in EMPTY discards the arriving instruction
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd3; in_wb_sel = 2'd0; in_alu_result = 32'h55; flush = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_empty_regwrite: got %b expected 0", RegWrite); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %b expected 1", in_ready); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL flush_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd1; in_wb_sel = 2'd2; in_pc_plus4 = 32'h0000_0104;
    step();
    in_rd = 5'd2; in_wb_sel = 2'd0; in_alu_result = 32'h0000_CAFE;
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL jal_regwrite: got %b expected 1", RegWrite); end
    n_checks++; if (rd !== 5'd1) begin n_fail++; $display("FAIL jal_rd: got %0d expected 1", rd); end
    n_checks++; if (rd_write_data !== 32'h0000_0104) begin n_fail++; $display("FAIL jal_data: got %h expected 00000104", rd_write_data); end
    step();
    idle_inputs();
    exp_cnt++;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL b2b_regwrite: got %b expected 1", RegWrite); end
    n_checks++; if (rd !== 5'd2) begin n_fail++; $display("FAIL b2b_rd: got %0d expected 2", rd); end
    n_checks++; if (rd_write_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL b2b_data: got %h expected 0000cafe", rd_write_data); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL b2b_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %b expected 0", RegWrite); end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd7; in_wb_sel = 2'd1; in_funct3 = 3'd2;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 64'd0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstload_ready: got %b expected 1", in_ready); end
    step();
    idle_inputs();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rstload_regwrite: got %b expected 0", RegWrite); end
    n_checks++; if (rd_write_data !== 32'd0) begin n_fail++; $display("FAIL rstload_data: got %h expected 0", rd_write_data); end
`ifdef RETIRE_CNT_EN
    n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL rstload_instret: got %0d expected %0d", instret, exp_cnt); end
`endif
  endtask

  task automatic test_random(input int cycles);
    bit          busy, killed, m_rw, exp_rw;
    logic [4:0]  m_rd, exp_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic [31:0] exp_data;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy = 1'b0; killed = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_f3 = 3'd0; m_lo = 2'd0;
    exp_rd = 5'd0; exp_data = 32'd0; exp_cnt = 64'd0;
    for (int c = 0; c < cycles; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_reg_write  = ($urandom_range(0, 7) != 0);
      in_rd         = 5'($urandom);
      in_wb_sel     = 2'($urandom);
      in_funct3     = 3'($urandom);
      in_addr_lo    = 2'($urandom);
      in_alu_result = $urandom;
      in_pc_plus4   = $urandom;
      flush         = ($urandom_range(0, 9) == 0);
      dmem_rvalid   = ($urandom_range(0, 2) == 0);
      dmem_rdata    = $urandom;
      n_checks++; if (in_ready !== (busy ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, in_ready, !busy); end
      exp_rw = 1'b0;
      if (!busy) begin
        if (in_valid && !flush) begin
          if (in_wb_sel == 2'd1) begin
            busy = 1'b1; killed = 1'b0;
            m_rw = in_reg_write; m_rd = in_rd; m_f3 = in_funct3; m_lo = in_addr_lo;
          end else begin
            exp_cnt++;
            if (in_reg_write && in_rd != 5'd0) begin
              exp_rw = 1'b1; exp_rd = in_rd;
              exp_data = (in_wb_sel == 2'd2) ? in_pc_plus4 : in_alu_result;
            end
          end
        end
      end else if (dmem_rvalid) begin
        busy = 1'b0;
        if (!killed && !flush) begin
          exp_cnt++;
          if (m_rw && m_rd != 5'd0) begin
            exp_rw = 1'b1; exp_rd = m_rd; exp_data = ref_load(m_f3, m_lo, dmem_rdata);
          end
        end
      end else if (flush) begin
        killed = 1'b1;
      end
      step();
      n_checks++; if (RegWrite !== exp_rw) begin n_fail++; $display("FAIL rand_regwrite c=%0d: got %b expected %b", c, RegWrite, exp_rw); end
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rd c=%0d: got %0d expected %0d", c, rd, exp_rd); end
      n_checks++; if (rd_write_data !== exp_data) begin n_fail++; $display("FAIL rand_data c=%0d: got %h expected %h", c, rd_write_data, exp_data); end
`ifdef RETIRE_CNT_EN
      n_checks++; if (instret !== exp_cnt) begin n_fail++; $display("FAIL rand_instret c=%0d: got %0d expected %0d", c, instret, exp_cnt); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_rd_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid_load();
    test_random(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
